// File: rtl/div_unit.sv
// div_unit: sequential signed restoring divider, MIPS DIV semantics.
// Quotient goes to lo, remainder to hi; DivStop/DivZero are 1-cycle pulses.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   DivCtrl         start request, sampled only in IDLE
//   a, b            dividend and divisor (signed)
//   hi, lo          registered remainder and quotient
//   DivStop         pulse: hi/lo hold a new result
//   DivZero         pulse: divisor was zero, no result
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             DivStop,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] dvd, dvd_n;
  logic [WIDTH-1:0] dsr, dsr_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             sq, sq_n;
  logic             sr, sr_n;
  logic             stop_n, zero_n;

  // Shifted remainder is WIDTH+1 bits so a 2^(WIDTH-1) divisor compares
  // correctly. When ge holds the difference is below dsr, so its low
  // WIDTH bits are exact.
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] sub;
  logic             ge;

  assign shl = {rem, dvd[WIDTH-1]};
  assign ge  = shl >= {1'b0, dsr};
  assign sub = shl[WIDTH-1:0] - dsr;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    dvd_n   = dvd;
    dsr_n   = dsr;
    sq_n    = sq;
    sr_n    = sr;
    hi_n    = hi;
    lo_n    = lo;
    stop_n  = 1'b0;
    zero_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (DivCtrl) begin
          if (b == '0) begin
            zero_n = 1'b1;
          end else begin
            dvd_n   = a[WIDTH-1] ? -a : a;
            dsr_n   = b[WIDTH-1] ? -b : b;
            sq_n    = a[WIDTH-1] ^ b[WIDTH-1];
            sr_n    = a[WIDTH-1];
            rem_n   = '0;
            cnt_n   = '0;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        rem_n = ge ? sub : shl[WIDTH-1:0];
        dvd_n = {dvd[WIDTH-2:0], ge};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_n = FIX;
      end
      FIX: begin
        lo_n    = sq ? -dvd : dvd;
        hi_n    = sr ? -rem : rem;
        stop_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      DivStop <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rem     <= rem_n;
      dvd     <= dvd_n;
      dsr     <= dsr_n;
      sq      <= sq_n;
      sr      <= sr_n;
      hi      <= hi_n;
      lo      <= lo_n;
      DivStop <= stop_n;
      DivZero <= zero_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector bench for div_unit.
// Table-driven divisions plus hand-written multi-cycle sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DivCtrl = 1'b0;
  logic [31:0] ai = '0;
  logic [31:0] bi = '0;
  logic [31:0] hi, lo;
  logic        DivStop, DivZero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .DivCtrl(DivCtrl),
    .a(ai),
    .b(bi),
    .hi(hi),
    .lo(lo),
    .DivStop(DivStop),
    .DivZero(DivZero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    DivCtrl = 1'b1;
    ai = a;
    bi = b;
    @(negedge clk);
    DivCtrl = 1'b0;
  endtask

  // Counts edges after the start edge until DivStop shows, bounded.
  task automatic wait_stop(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!DivStop && n < 100);
  endtask

  task automatic run_div(input string nm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi);
    int n;
    start(a, b);
    wait_stop(n);
    chk({nm, " latency"}, 32'(n), 32'd33);
    chk({nm, " lo"}, lo, elo);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " zero"}, {31'd0, DivZero}, 32'd0);
    @(negedge clk);
    chk({nm, " stop width"}, {31'd0, DivStop}, 32'd0);
  endtask

  initial begin
    int n;
    int stops;

    tbl[0] = '{32'd100,       32'd7,         32'd14,        32'd2};
    tbl[1] = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE};
    tbl[2] = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2};
    tbl[3] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE};
    tbl[4] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
    tbl[5] = '{32'd7,         32'h80000000,  32'd0,         32'd7};
    tbl[6] = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};
    tbl[7] = '{32'h7FFFFFFF,  32'h10,        32'h07FFFFFF,  32'hF};
    tbl[8] = '{32'd3,         32'hFFFFFFFE,  32'hFFFFFFFF,  32'd1};
    tbl[9] = '{32'hFFFFFFFD,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFF};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst stop", {31'd0, DivStop}, 32'd0);
    chk("rst zero", {31'd0, DivZero}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
              tbl[i].lo, tbl[i].hi);
    end

    // Divide by zero keeps the previous result.
    run_div("pre0", 32'd100, 32'd7, 32'd14, 32'd2);
    start(32'd5, 32'd0);
    chk("dz zero", {31'd0, DivZero}, 32'd1);
    chk("dz stop", {31'd0, DivStop}, 32'd0);
    @(negedge clk);
    chk("dz width", {31'd0, DivZero}, 32'd0);
    stops = 0;
    repeat (40) begin
      @(negedge clk);
      if (DivStop) stops++;
    end
    chk("dz no stop", 32'(stops), 32'd0);
    chk("dz lo", lo, 32'd14);
    chk("dz hi", hi, 32'd2);

    // Restart ignored mid-operation; operand changes ignored.
    run_div("pre1", 32'd9, 32'd3, 32'd3, 32'd0);
    start(32'd100, 32'd7);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (DivStop) break;
      if (n == 10) begin
        DivCtrl = 1'b1;
        ai = 32'd9;
        bi = 32'd3;
      end else if (n == 11) begin
        DivCtrl = 1'b0;
        ai = 32'd1;
        bi = 32'd0;
      end
    end
    chk("mid latency", 32'(n), 32'd33);
    chk("mid lo", lo, 32'd14);
    chk("mid hi", hi, 32'd2);
    chk("mid zero", {31'd0, DivZero}, 32'd0);

    // Back-to-back start in the DivStop cycle.
    DivCtrl = 1'b1;
    ai = 32'd9;
    bi = 32'd3;
    @(negedge clk);
    DivCtrl = 1'b0;
    chk("b2b stop width", {31'd0, DivStop}, 32'd0);
    wait_stop(n);
    chk("b2b latency", 32'(n), 32'd33);
    chk("b2b lo", lo, 32'd3);
    chk("b2b hi", hi, 32'd0);
    @(negedge clk);

    // Reset aborts a division in flight.
    run_div("pre2", 32'd100, 32'd7, 32'd14, 32'd2);
    start(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort stop", {31'd0, DivStop}, 32'd0);
    chk("abort zero", {31'd0, DivZero}, 32'd0);
    stops = 0;
    repeat (50) begin
      @(negedge clk);
      if (DivStop) stops++;
    end
    chk("abort no stop", 32'(stops), 32'd0);
    run_div("post", 32'd9, 32'd3, 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
